// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: cache-side and memory-side bus of the line-fill arbiter
interface cache_mem_arbiter_if #(parameter int ADDR_W = 16, parameter int LINE_W = 128);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  modport master (
    input  icache_read, icache_address, dcache_read, dcache_write, dcache_address, dcache_wdata,
           pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport slave (
    output icache_read, icache_address, dcache_read, dcache_write, dcache_address, dcache_wdata,
           pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises I-cache and D-cache line transfers onto one memory port
module cache_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  cache_mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
  state_t            state, next;
  logic              prio_d, wr_q, i_req, d_req, grant_i, grant_d, serving;
  logic [ADDR_W-1:0] addr_q, req_addr;
  logic [LINE_W-1:0] wdata_q;
  assign i_req    = bus.icache_read;
  assign d_req    = bus.dcache_read | bus.dcache_write;
  assign grant_d  = d_req & (prio_d | !i_req);
  assign grant_i  = i_req & !grant_d;
  assign req_addr = grant_d ? bus.dcache_address : bus.icache_address;
  assign serving  = state == SERVE_I || state == SERVE_D;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_d  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (state == IDLE && (grant_i || grant_d))
        addr_q <= {req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      if (state == IDLE && grant_d) begin
        wr_q    <= bus.dcache_write;
        wdata_q <= bus.dcache_wdata;
      end
      // fairness: the cache just served loses the next tie
      if (serving && bus.pmem_resp) prio_d <= state == SERVE_I;
    end
  end
  always_comb
    next = state == IDLE ? (grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE) :
           state == DONE ? IDLE :
           bus.pmem_resp ? DONE : state;
  always_comb begin
    bus.pmem_read    = state == SERVE_I || (state == SERVE_D && !wr_q);
    bus.pmem_write   = state == SERVE_D && wr_q;
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.icache_resp  = state == SERVE_I && bus.pmem_resp;
    bus.dcache_resp  = state == SERVE_D && bus.pmem_resp;
    bus.icache_rdata = bus.pmem_rdata;
    bus.dcache_rdata = bus.pmem_rdata;
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed stimulus with a resp-driven scoreboard monitor
module tb_cache_mem_arbiter;
  typedef struct {
    logic          is_d;
    logic [15:0]   addr;
    logic          wr;
    logic [127:0]  wdata;
    logic [127:0]  rdata;
    int            len;
  } exp_t;
  logic clk = 0, reset_n = 0;
  int checks = 0, failures = 0, cnt = 0;
  exp_t sb[$];
  cache_mem_arbiter_if bus();
  cache_mem_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic push(input logic is_d, input logic [15:0] addr, input logic wr,
                      input logic [127:0] wdata, input logic [127:0] rdata, input int len);
    exp_t e;
    e.is_d = is_d; e.addr = addr; e.wr = wr; e.wdata = wdata; e.rdata = rdata; e.len = len;
    sb.push_back(e);
  endtask
  task automatic mem_txn(input int wait_exp, input int lat, input logic [127:0] rd, input logic chg);
    int w = 0;
    do begin
      @(posedge clk); #1; w++;
    end while (!(bus.pmem_read || bus.pmem_write) && w < 20);
    chk("grant_delay", 128'(w), 128'(wait_exp));
    if (chg) begin
      bus.dcache_wdata = ~bus.dcache_wdata;
      bus.icache_read  = 1'b0;
    end
    repeat (lat - 1) begin @(posedge clk); #1; end
    bus.pmem_rdata = rd;
    bus.pmem_resp  = 1'b1;
    @(posedge clk); #1;
    bus.pmem_resp  = 1'b0;
    chk("done_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) cnt = 0;
    else begin
      if (bus.pmem_read || bus.pmem_write) cnt++;
      if (bus.icache_resp || bus.dcache_resp) begin
        if (sb.size() == 0) chk("unexpected_resp", {bus.icache_resp, bus.dcache_resp}, 2'b00);
        else begin
          e = sb.pop_front();
          chk("resp_src", {bus.icache_resp, bus.dcache_resp}, {!e.is_d, e.is_d});
          chk("pmem_address", bus.pmem_address, e.addr);
          chk("pmem_rw", {bus.pmem_read, bus.pmem_write}, {!e.wr, e.wr});
          chk("strobe_cycles", 128'(cnt), 128'(e.len));
          if (e.wr) chk("pmem_wdata", bus.pmem_wdata, e.wdata);
          else chk("rdata", e.is_d ? bus.dcache_rdata : bus.icache_rdata, e.rdata);
        end
        cnt = 0;
      end
    end
  end
  initial begin
    bus.icache_read = 0; bus.icache_address = '0;
    bus.dcache_read = 0; bus.dcache_write = 0; bus.dcache_address = '0; bus.dcache_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;
    #12;
    chk("rst_outputs", {bus.pmem_read, bus.pmem_write, bus.icache_resp, bus.dcache_resp,
                        bus.pmem_address, bus.pmem_wdata}, '0);
    @(posedge clk); #1; reset_n = 1;
    @(posedge clk); #1;
    // reset in the middle of a write-back
    bus.dcache_write = 1; bus.dcache_address = 16'h2004; bus.dcache_wdata = {4{32'h1234_5678}};
    begin
      int w = 0;
      do begin @(posedge clk); #1; w++; end while (!bus.pmem_write && w < 20);
      chk("rst_test_grant", 128'(bus.pmem_write), 128'(1));
    end
    @(posedge clk); #3;
    reset_n = 0; #1;
    chk("async_rst_outputs", {bus.pmem_read, bus.pmem_write, bus.icache_resp, bus.dcache_resp,
                              bus.pmem_address, bus.pmem_wdata}, '0);
    @(posedge clk); #1;
    bus.dcache_write = 0; bus.dcache_wdata = '0;
    reset_n = 1;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);
    // contention from reset: D first, then I wins the re-contention
    bus.icache_read = 1; bus.icache_address = 16'h0040;
    bus.dcache_read = 1; bus.dcache_address = 16'h8000;
    push(1, 16'h8000, 0, '0, {8{16'h1111}}, 2);
    mem_txn(1, 2, {8{16'h1111}}, 0);
    bus.dcache_address = 16'h8010;
    push(0, 16'h0040, 0, '0, {8{16'h2222}}, 3);
    push(1, 16'h8010, 0, '0, {8{16'h3333}}, 1);
    mem_txn(2, 3, {8{16'h2222}}, 0);
    bus.icache_read = 0;
    mem_txn(2, 1, {8{16'h3333}}, 0);
    bus.dcache_read = 0;
    @(posedge clk); #1;
    // lone I-miss
    bus.icache_read = 1; bus.icache_address = 16'h1234;
    push(0, 16'h1230, 0, '0, {16{8'hA5}}, 5);
    mem_txn(1, 5, {16{8'hA5}}, 0);
    bus.icache_read = 0;
    @(posedge clk); #1;
    // D write-back with wdata changing after grant
    bus.dcache_write = 1; bus.dcache_address = 16'h3FFF;
    bus.dcache_wdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    push(1, 16'h3FF0, 1, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, '0, 3);
    mem_txn(1, 3, '0, 1);
    bus.dcache_write = 0;
    @(posedge clk); #1;
    // I request withdrawn one cycle after grant
    bus.icache_read = 1; bus.icache_address = 16'h0105;
    push(0, 16'h0100, 0, '0, {4{32'hCAFE_F00D}}, 4);
    mem_txn(1, 4, {4{32'hCAFE_F00D}}, 1);
    @(posedge clk); #1;
    // spurious pmem_resp in IDLE
    bus.pmem_resp = 1;
    @(posedge clk); #1;
    bus.pmem_resp = 0;
    chk("spurious_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    bus.dcache_read = 1; bus.dcache_address = 16'h0A0C;
    push(1, 16'h0A00, 0, '0, {8{16'h5A5A}}, 1);
    mem_txn(1, 1, {8{16'h5A5A}}, 0);
    bus.dcache_read = 0;
    repeat (20) begin
      if (sb.size() != 0) begin @(posedge clk); #1; end
    end
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
